// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {ISSUE, WAIT, DROP, HOLD} fetch_state_t;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

endpackage

// File: rtl/register_with_rst_and_en.sv
// Plain data register with synchronous active-high clear and load enable.
module register_with_rst_and_en #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one imem request at a time, hands words
// to the core with valid/ready and flushes stale responses after redirects or timeouts.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               cpu_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [CNT_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic              fetch_err_reg, fetch_err_next;
    logic              instr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ISSUE;
            pc_reg        <= RESET_PC;
            tmo_cnt_reg   <= '0;
            fetch_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            fetch_err_reg <= fetch_err_next;
        end
    end

    // Counter only advances while staying in WAIT, so any exit clears it.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        tmo_cnt_next   = '0;
        fetch_err_next = fetch_err_reg;
        instr_en       = 1'b0;
        case (state_reg)
            ISSUE: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = DROP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid) begin
                        pc_next    = redirect_pc;
                        state_next = ISSUE;
                    end else begin
                        instr_en   = 1'b1;
                        state_next = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = DROP;
                end else if (tmo_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    fetch_err_next = 1'b1;
                    state_next     = DROP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end
                if (imem_rsp_valid) begin
                    state_next = ISSUE;
                end
            end
            HOLD: begin
                // A redirect wins over ready: the held word is discarded, not consumed.
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = ISSUE;
                end else if (cpu_ready) begin
                    pc_next    = pc_reg + ADDR_W'(PC_STEP);
                    state_next = ISSUE;
                end
            end
            default: state_next = ISSUE;
        endcase
    end

    register_with_rst_and_en #(
        .W (INSTR_W)
    ) u_instr_reg (
        .clk (clk),
        .rst (rst),
        .en  (instr_en),
        .d   (imem_rsp_data),
        .q   (instr)
    );

    assign imem_req    = (state_reg == ISSUE) & ~rst;
    assign imem_addr   = pc_reg;
    assign instr_valid = (state_reg == HOLD);
    assign instr_pc    = pc_reg;
    assign fetch_err   = fetch_err_reg;

endmodule
